// File: rtl/bin_to_bcd_seq_if.sv
// Valid/ready bundle for bin_to_bcd_seq: binary operand in, packed BCD digits out.
// The converter takes the slave view; the producer/consumer side takes the master view.
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic [WIDTH-1:0]    in_data;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] out_data;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Each output nibble feeds one downstream Excess-3 converter; digit 0 is the units digit.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input logic             clk,
  input logic             rst_n,
  bin_to_bcd_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;
  localparam logic [63:0] MAX_BIN = (64'd1 << WIDTH) - 64'd1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  if (pow10(DIGITS) <= MAX_BIN) begin : g_digits_too_small
    $error("bin_to_bcd_seq: DIGITS=%0d cannot represent 2**%0d-1", DIGITS, WIDTH);
  end

  // Add 3 to every digit that is 5 or more, so the following doubling carries correctly.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [CNT_W-1:0]   count_q;
  logic [BCD_W-1:0]   out_q;
  logic               out_valid_q;
  logic               in_ready_q;

  logic [BCD_W+WIDTH-1:0] shift_d;
  logic [BCD_W-1:0]       bcd_d;
  logic [WIDTH-1:0]       bin_d;

  // One dabble step: adjust the digits, then shift {bcd,bin} left by one bit.
  always_comb begin
    shift_d = {dabble_adjust(bcd_q), bin_q} << 1'b1;
    bcd_d   = shift_d[BCD_W+WIDTH-1 -: BCD_W];
    bin_d   = shift_d[WIDTH-1:0];
  end

  // Control FSM with all datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      count_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            bin_q      <= bus.in_data;
            bcd_q      <= '0;
            count_q    <= CNT_W'(WIDTH);
            in_ready_q <= 1'b0;
            state_q    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bcd_q   <= bcd_d;
          bin_q   <= bin_d;
          count_q <= count_q - CNT_W'(1);
          // The last shift lands straight in the output register.
          if (count_q == CNT_W'(1)) begin
            out_q       <= bcd_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          // out_q is deliberately left holding the last result.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          count_q     <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_data  = out_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: accepts push a decimal reference result,
// a negedge monitor pops and compares on every output handshake.
module tb_bin_to_bcd_seq;
  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int BCD_W  = 4 * DIGITS;

  typedef struct {
    logic [BCD_W-1:0] bcd;
    int               acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   hs_count = 0;
  exp_t sbq[$];
  bit   exp_busy = 1'b0;
  bit   rdy_forced;
  bit   rdy_val;

  bit               prev_valid = 1'b0;
  bit               hs_prev = 1'b0;
  logic [BCD_W-1:0] last_out = '0;
  logic [BCD_W-1:0] hs_val = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin_to_bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Reference: digit i is (v / 10**i) mod 10.
  function automatic logic [BCD_W-1:0] ref_bcd(input int v);
    logic [BCD_W-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int bad_digits(input logic [BCD_W-1:0] b);
    int n;
    n = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] > 4'd9) n++;
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: handshake-side checks and the accept watcher that feeds the scoreboard.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        hs_prev    = 1'b0;
      end else begin
        if (hs_prev) begin
          check("valid_drop_after_hs", 64'(bus.out_valid), 64'd0);
          check("in_ready_after_hs", 64'(bus.in_ready), 64'd1);
          check("out_kept_after_hs", 64'(bus.out_data), 64'(hs_val));
        end
        hs_prev = 1'b0;
        if (exp_busy && bus.in_ready) check("in_ready_while_busy", 64'(bus.in_ready), 64'd0);
        if (bus.out_valid && !prev_valid) begin
          check("latency_has_pending", 64'(sbq.size() != 0), 64'd1);
          if (sbq.size() != 0) check("latency", 64'(cyc - sbq[0].acc), 64'(WIDTH));
        end
        if (bus.out_valid && prev_valid) check("out_stable", 64'(bus.out_data), 64'(last_out));
        if (bus.out_valid && bus.out_ready) begin
          check("out_has_pending", 64'(sbq.size() != 0), 64'd1);
          if (sbq.size() != 0) begin
            check("bcd_value", 64'(bus.out_data), 64'(sbq[0].bcd));
            void'(sbq.pop_front());
          end
          check("digit_range", 64'(bad_digits(bus.out_data)), 64'd0);
          hs_val   = bus.out_data;
          hs_prev  = 1'b1;
          exp_busy = 1'b0;
          hs_count++;
        end
        if (bus.in_valid && bus.in_ready) begin
          sbq.push_back('{bcd: ref_bcd(int'(bus.in_data)), acc: cyc + 1});
          exp_busy = 1'b1;
        end
        prev_valid = bus.out_valid;
        last_out   = bus.out_data;
      end
    end
  end

  // Consumer side: forced level or random backpressure.
  initial begin : ready_drv
    forever begin
      @(posedge clk);
      #1;
      if (rdy_forced) bus.out_ready = rdy_val;
      else bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input int v);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = WIDTH'(v);
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("send_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.out_valid) ok = 1'b1;
    end
    check("wait_out_valid", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sbq.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("drain_empty", 64'(sbq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int hs_before;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b0;
    rdy_forced   = 1'b1;
    rdy_val      = 1'b1;
    gap(2);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out", 64'(bus.out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    gap(1);

    // T1/T2 directed values
    send(0);
    drain();
    send(255);
    send(99);
    send(100);
    drain();

    // T2 exhaustive and random with random backpressure
    rdy_forced = 1'b0;
    for (int v = 0; v < 256; v++) begin
      gap($urandom_range(0, 2));
      send(v);
    end
    for (int k = 0; k < 40; k++) send(int'($urandom_range(0, 255)));
    drain();

    // T3 backpressure
    rdy_forced = 1'b1;
    rdy_val    = 1'b0;
    send(200);
    wait_valid();
    repeat (20) @(negedge clk);
    check("t3_valid_held", 64'(bus.out_valid), 64'd1);
    check("t3_out", 64'(bus.out_data), 64'h200);
    check("t3_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    rdy_val = 1'b1;
    drain();

    // T4 in_valid kept high with changing data during SHIFT
    hs_before = hs_count;
    send(37);
    bus.in_valid = 1'b1;
    bus.in_data  = WIDTH'(5);
    gap(3);
    bus.in_data  = WIDTH'(250);
    gap(3);
    bus.in_valid = 1'b0;
    drain();
    check("t4_one_conversion", 64'(hs_count - hs_before), 64'd1);

    // T5 reset in the middle of SHIFT
    send(180);
    gap(3);
    rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("t5_rst_out", 64'(bus.out_data), 64'd0);
    check("t5_rst_in_ready", 64'(bus.in_ready), 64'd1);
    sbq.delete();
    exp_busy = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    gap(1);
    send(42);
    drain();

    // T6 Excess-3 view of each digit
    rdy_val = 1'b0;
    send(59);
    wait_valid();
    check("t6_xs3_d2", 64'(4'(bus.out_data[11:8] + 4'd3)), 64'h3);
    check("t6_xs3_d1", 64'(4'(bus.out_data[7:4] + 4'd3)), 64'h8);
    check("t6_xs3_d0", 64'(4'(bus.out_data[3:0] + 4'd3)), 64'hC);
    @(posedge clk);
    #1;
    rdy_val = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
